// File: rtl/char_scan_reader.sv
// char_scan_reader
//
// Read-side scanout engine for the 80x32 text character buffer. It converts
// VGA timing into character-buffer reads and font-ROM reads, then emits a
// 1-bit pixel stream with an underline cursor overlay. All timing outputs
// are delayed 3 clk so they stay aligned with pixelOut.
//
// Optional build macro: CURSOR_BLINK_EN
//   defined   - 5-bit frame counter on vsync rising edges; cursor is shown
//               while frameCount[4]=1 (16 frames on, 16 frames off).
//   undefined - cursor is steady; no frame counter is built.
//
// Ports:
//   clk, resetn              pixel clock, synchronous active-low reset
//   hCountIn, deIn           horizontal pixel index and display enable
//   hsyncIn, vsyncIn         syncs (vsyncIn also clears the line counters)
//   scrollRow                buffer row shown on screen row 0
//   cursorRow/Col/Enable     cursor position and overlay enable
//   charRdAddr / charRdData  buffer read port {col, bufRow}, 1-cycle RAM
//   fontAddr / fontData      font read port {char, fontLine}, 1-cycle ROM
//   pixelOut                 pixel value, forced 0 outside display enable
//   deOut, hsyncOut, vsyncOut  inputs delayed to align with pixelOut
module char_scan_reader #(
    parameter int FONT_LINES = 15,
    parameter int MAXROW_M_1 = 31
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  hCountIn,
    input  logic        deIn,
    input  logic        hsyncIn,
    input  logic        vsyncIn,
    input  logic [4:0]  scrollRow,
    input  logic [4:0]  cursorRow,
    input  logic [6:0]  cursorCol,
    input  logic        cursorEnable,
    output logic [11:0] charRdAddr,
    input  logic [6:0]  charRdData,
    output logic [10:0] fontAddr,
    input  logic [7:0]  fontData,
    output logic        pixelOut,
    output logic        deOut,
    output logic        hsyncOut,
    output logic        vsyncOut
);

    localparam logic [3:0] LAST_LINE   = 4'(FONT_LINES - 1);
    localparam logic [3:0] CURSOR_LINE = 4'(FONT_LINES - 2);
    localparam logic [4:0] LAST_ROW    = 5'(MAXROW_M_1);

    logic [3:0] fontLine_q, fontLine_d;
    logic [4:0] screenRow_q, screenRow_d;
    logic [4:0] bufRow;

    logic [2:0] x_p1_q, x_p2_q;
    logic [3:0] fontLine_p1_q, fontLine_p2_q;
    logic [4:0] screenRow_p1_q, screenRow_p2_q;
    logic [6:0] col_p1_q, col_p2_q;
    logic       vld_p1_q, vld_p2_q;
    logic       hs_p1_q, hs_p2_q;
    logic       vs_p1_q, vs_p2_q;

    logic       cursorVisible;
    logic       cursorHit;
    logic       rawPixel;

    // Bit 7 of a font row is the leftmost pixel of the cell.
    function automatic logic font_bit(input logic [7:0] row, input logic [2:0] x);
        font_bit = row[3'd7 - x];
    endfunction

    // Line counters advance on each falling edge of display enable;
    // vsync has priority and holds both at zero.
    always_comb begin
        fontLine_d  = fontLine_q;
        screenRow_d = screenRow_q;
        if (vsyncIn) begin
            fontLine_d  = '0;
            screenRow_d = '0;
        end else if (vld_p1_q && !deIn) begin
            if (fontLine_q == LAST_LINE) begin
                fontLine_d  = '0;
                screenRow_d = (screenRow_q == LAST_ROW) ? '0 : screenRow_q + 5'd1;
            end else begin
                fontLine_d = fontLine_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fontLine_q  <= '0;
            screenRow_q <= '0;
        end else begin
            fontLine_q  <= fontLine_d;
            screenRow_q <= screenRow_d;
        end
    end

    // 5-bit add wraps naturally, so the row above scrollRow lands on
    // screen row 31 (the status row). In reset the counters are treated as 0.
    assign bufRow     = resetn ? (screenRow_q + scrollRow) : scrollRow;
    assign charRdAddr = {hCountIn[9:3], bufRow};

    // ---- stage 1: registered copies aligned with charRdData ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_p1_q         <= '0;
            fontLine_p1_q  <= '0;
            screenRow_p1_q <= '0;
            col_p1_q       <= '0;
            vld_p1_q       <= 1'b0;
            hs_p1_q        <= 1'b0;
            vs_p1_q        <= 1'b0;
        end else begin
            x_p1_q         <= hCountIn[2:0];
            fontLine_p1_q  <= fontLine_q;
            screenRow_p1_q <= screenRow_q;
            col_p1_q       <= hCountIn[9:3];
            vld_p1_q       <= deIn;
            hs_p1_q        <= hsyncIn;
            vs_p1_q        <= vsyncIn;
        end
    end

    assign fontAddr = {charRdData, fontLine_p1_q};

    // ---- stage 2: registered copies aligned with fontData ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_p2_q         <= '0;
            fontLine_p2_q  <= '0;
            screenRow_p2_q <= '0;
            col_p2_q       <= '0;
            vld_p2_q       <= 1'b0;
            hs_p2_q        <= 1'b0;
            vs_p2_q        <= 1'b0;
        end else begin
            x_p2_q         <= x_p1_q;
            fontLine_p2_q  <= fontLine_p1_q;
            screenRow_p2_q <= screenRow_p1_q;
            col_p2_q       <= col_p1_q;
            vld_p2_q       <= vld_p1_q;
            hs_p2_q        <= hs_p1_q;
            vs_p2_q        <= vs_p1_q;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [4:0] frameCount_q;

    // vs_p1_q is last cycle's vsyncIn, so this counts vsync rising edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frameCount_q <= '0;
        end else if (vsyncIn && !vs_p1_q) begin
            frameCount_q <= frameCount_q + 5'd1;
        end
    end

    assign cursorVisible = frameCount_q[4];
`else
    assign cursorVisible = 1'b1;
`endif

    // Underline cursor: last two scanlines of the selected cell.
    assign cursorHit = cursorEnable & cursorVisible
                     & (screenRow_p2_q == cursorRow)
                     & (col_p2_q == cursorCol)
                     & (fontLine_p2_q >= CURSOR_LINE);

    assign rawPixel = font_bit(fontData, x_p2_q);

    // ---- stage 3: registered outputs ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pixelOut <= 1'b0;
            deOut    <= 1'b0;
            hsyncOut <= 1'b0;
            vsyncOut <= 1'b0;
        end else begin
            pixelOut <= (rawPixel ^ cursorHit) & vld_p2_q;
            deOut    <= vld_p2_q;
            hsyncOut <= hs_p2_q;
            vsyncOut <= vs_p2_q;
        end
    end

endmodule

// File: tb/tb_char_scan_reader.sv
`timescale 1ns/1ps
module tb_char_scan_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  hCountIn;
    logic        deIn, hsyncIn, vsyncIn;
    logic [4:0]  scrollRow, cursorRow;
    logic [6:0]  cursorCol;
    logic        cursorEnable;
    logic [11:0] charRdAddr;
    logic [6:0]  charRdData;
    logic [10:0] fontAddr;
    logic [7:0]  fontData;
    logic        pixelOut, deOut, hsyncOut, vsyncOut;

    always #5 clk = ~clk;

    char_scan_reader dut (
        .clk(clk), .resetn(resetn), .hCountIn(hCountIn), .deIn(deIn),
        .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .scrollRow(scrollRow),
        .cursorRow(cursorRow), .cursorCol(cursorCol), .cursorEnable(cursorEnable),
        .charRdAddr(charRdAddr), .charRdData(charRdData), .fontAddr(fontAddr),
        .fontData(fontData), .pixelOut(pixelOut), .deOut(deOut),
        .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
    );

    // Environment: character buffer and font ROM, both 1-cycle synchronous.
    logic [6:0] mem  [0:4095];
    logic [7:0] font [0:2047];
    always @(posedge clk) begin
        charRdData <= mem[charRdAddr];
        fontData   <= font[fontAddr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int HN = 65536;
    logic [9:0] h_h   [HN];
    bit         de_h  [HN];
    bit         hs_h  [HN];
    bit         vs_h  [HN];
    bit         rst_h [HN];
    logic [4:0] sc_h  [HN];
    int         lines_h [HN];
    bit         out_log [HN];

    int  cyc = 0;
    int  lines = 0;      // display lines since vsync/reset (counted by de falls)
    int  frames = 0;     // vsync rising edges since reset, mod 32
    bit  de_prev = 0, vs_prev = 0;
    logic [3:0] exp_out = '0;

    int m_k, m_fl, m_row, m_br, m_x;
    logic [9:0] m_h;
    logic [6:0] m_ch;
    logic [7:0] m_f;
    bit m_raw, m_cur, m_vis;

    always @(posedge clk) begin
        if (cyc < HN) begin
            h_h[cyc] = hCountIn;  de_h[cyc] = deIn;   hs_h[cyc] = hsyncIn;
            vs_h[cyc] = vsyncIn;  rst_h[cyc] = !resetn;
            sc_h[cyc] = scrollRow; lines_h[cyc] = lines;
            exp_out = 4'b0000;
            if (cyc >= 2 && !rst_h[cyc] && !rst_h[cyc-1] && !rst_h[cyc-2]) begin
                m_k   = cyc - 2;
                m_h   = h_h[m_k];
                m_fl  = lines_h[m_k] % 15;
                m_row = (lines_h[m_k] / 15) % 32;
                m_br  = (m_row + int'(sc_h[m_k])) % 32;
                m_ch  = mem[{m_h[9:3], 5'(m_br)}];
                m_f   = font[{m_ch, 4'(m_fl)}];
                m_x   = int'(m_h) % 8;
                m_raw = m_f[7 - m_x];
`ifdef CURSOR_BLINK_EN
                m_vis = (frames >= 16);
`else
                m_vis = 1'b1;
`endif
                m_cur = cursorEnable && m_vis && (m_row == int'(cursorRow))
                        && ((int'(m_h) / 8) == int'(cursorCol)) && (m_fl >= 13);
                exp_out = {de_h[m_k] & (m_raw ^ m_cur), de_h[m_k], hs_h[m_k], vs_h[m_k]};
            end
            if (!resetn) begin
                lines = 0; frames = 0; de_prev = 0; vs_prev = 0;
            end else begin
                if (vsyncIn) lines = 0;
                else if (de_prev && !deIn) lines = lines + 1;
                if (vsyncIn && !vs_prev) frames = (frames + 1) % 32;
                de_prev = deIn;
                vs_prev = vsyncIn;
            end
        end
        cyc++;
    end

    logic [11:0] exp_addr;
    always @(negedge clk) begin
        if (cyc >= 3 && cyc <= HN) begin
            out_log[cyc-3] = pixelOut;
            check("outputs{pix,de,hs,vs}", 32'({pixelOut, deOut, hsyncOut, vsyncOut}), 32'(exp_out));
            if (resetn)
                exp_addr = {hCountIn[9:3], 5'(((lines / 15) + int'(scrollRow)) % 32)};
            else
                exp_addr = {hCountIn[9:3], scrollRow};
            check("charRdAddr", 32'(charRdAddr), 32'(exp_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        deIn = 0; hsyncIn = 0; vsyncIn = 0;
        repeat (n) tick();
    endtask

    task automatic vsync_pulse();
        deIn = 0; hsyncIn = 0; vsyncIn = 1;
        tick(); tick();
        vsyncIn = 0;
        tick();
    endtask

    task automatic do_reset();
        resetn = 0; deIn = 0; hsyncIn = 0; vsyncIn = 0;
        tick(); tick();
        resetn = 1;
    endtask

    int mk_g [8];
    int mk_c [4][24];
    int mk_b [16];
    int mk_f [64];
    logic [7:0] glyph = 8'b00011000;

    task automatic cursor_frame(input bit en);
        bit expv;
        cursorRow = 5'd2; cursorCol = 7'd10; cursorEnable = en; scrollRow = 5'd0;
        vsync_pulse();
        for (int ln = 0; ln < 46; ln++) begin
            for (int x = 72; x < 96; x++) begin
                hCountIn = 10'(x); deIn = 1;
                if (ln >= 42) mk_c[ln-42][x-72] = cyc;
                tick();
            end
            deIn = 0; hsyncIn = 1; tick();
            hsyncIn = 0; tick();
        end
        idle(4);
        for (int l = 0; l < 4; l++)
            for (int x = 0; x < 24; x++) begin
                expv = en && (l == 1 || l == 2) && (x >= 8) && (x < 16);
                check("cursor pixel", 32'(out_log[mk_c[l][x]]), 32'(expv));
            end
    endtask

    initial begin
        int len, start, gap;
        bit expv;

        for (int i = 0; i < 4096; i++) mem[i]  = 7'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        mem[{7'd0, 5'd0}]   = 7'h41;
        font[{7'h41, 4'd0}] = 8'b00011000;
        mem[{7'd1, 5'd0}]   = 7'h7F;
        font[{7'h7F, 4'd0}] = 8'hFF;
        for (int l = 0; l < 16; l++) font[{7'h00, 4'(l)}] = 8'h00;
        for (int c = 9; c <= 11; c++) begin
            mem[{7'(c), 5'd2}] = 7'h00;
            mem[{7'(c), 5'd3}] = 7'h00;
        end

        // Reset state
        resetn = 0; hCountIn = 10'd83; deIn = 0; hsyncIn = 0; vsyncIn = 0;
        scrollRow = 5'd5; cursorRow = 0; cursorCol = 0; cursorEnable = 0;
        tick(); tick();
        check("reset pixelOut", 32'(pixelOut), 32'd0);
        check("reset syncs", 32'({deOut, hsyncOut, vsyncOut}), 32'd0);
        check("reset charRdAddr", 32'(charRdAddr), 32'({7'd10, 5'd5}));
        resetn = 1;

        // Latency / glyph on first active line
        scrollRow = 5'd0;
        vsync_pulse();
        for (int i = 0; i < 8; i++) begin
            hCountIn = 10'(i); deIn = 1; mk_g[i] = cyc; tick();
        end
        idle(4);
        for (int i = 0; i < 8; i++)
            check("glyph pixel", 32'(out_log[mk_g[i]]), 32'(glyph[7-i]));

        // Line counting
        vsync_pulse();
        tick();
        check("fontLine start", 32'(fontAddr[3:0]), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            hCountIn = 10'd0; deIn = 1; tick();
            deIn = 0; tick(); tick();
            check("fontLine", 32'(fontAddr[3:0]), 32'(i % 15));
            check("screenRow", 32'(charRdAddr[4:0]), 32'(i / 15));
        end
        deIn = 1; tick();
        deIn = 0; vsyncIn = 1; tick();
        vsyncIn = 0; tick(); tick();
        check("vsync vs de fall fontLine", 32'(fontAddr[3:0]), 32'd0);
        check("vsync vs de fall screenRow", 32'(charRdAddr[4:0]), 32'd0);

        // Scroll wrap at screen row 31
        vsync_pulse();
        repeat (465) begin
            deIn = 1; tick();
            deIn = 0; tick();
        end
        scrollRow = 5'd5; #1;
        check("status row bufRow", 32'(charRdAddr[4:0]), 32'd4);
        scrollRow = 5'd0; #1;
        check("row31 bufRow", 32'(charRdAddr[4:0]), 32'd31);
        tick();

        // Cursor underline, enabled then disabled
        cursor_frame(1'b1);
        cursor_frame(1'b0);

        // Blanking and mid-line reset
        cursorEnable = 0; scrollRow = 5'd0;
        vsync_pulse();
        for (int x = 8; x < 16; x++) begin
            hCountIn = 10'(x); deIn = 0; mk_b[x-8] = cyc; tick();
        end
        hsyncIn = 1;
        for (int x = 8; x < 16; x++) begin
            hCountIn = 10'(x); deIn = 1; mk_b[x] = cyc; tick();
        end
        check("active pixel before reset", 32'({pixelOut, deOut, hsyncOut}), 32'b111);
        resetn = 0; hCountIn = 10'd8; #1;
        check("charRdAddr in reset", 32'(charRdAddr), 32'({7'd1, scrollRow}));
        tick();
        check("mid-line reset outputs", 32'({pixelOut, deOut, hsyncOut, vsyncOut}), 32'd0);
        resetn = 1;
        idle(4);
        for (int i = 0; i < 8; i++) check("blanked pixel", 32'(out_log[mk_b[i]]), 32'd0);
        for (int i = 8; i < 14; i++) check("unblanked pixel", 32'(out_log[mk_b[i]]), 32'd1);

        // Randomized traffic
        do_reset();
        for (int ln = 0; ln < 400; ln++) begin
            if ($urandom_range(0, 39) == 0) begin
                vsyncIn = 1;
                repeat ($urandom_range(1, 3)) tick();
                vsyncIn = 0;
            end
            len   = $urandom_range(1, 24);
            start = $urandom_range(0, 639 - len);
            if ($urandom_range(0, 3) == 0) begin
                cursorRow    = 5'($urandom_range(0, 3));
                cursorCol    = 7'((start + $urandom_range(0, len - 1)) / 8);
                cursorEnable = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < len; i++) begin
                hCountIn = 10'(start + i); deIn = 1; hsyncIn = 0;
                if ($urandom_range(0, 7) == 0) scrollRow = 5'($urandom);
                resetn = ($urandom_range(0, 299) != 0);
                tick();
            end
            resetn = 1; deIn = 0; hCountIn = 10'($urandom);
            gap = $urandom_range(1, 3);
            hsyncIn = 1; tick();
            hsyncIn = 0;
            repeat (gap - 1) tick();
        end
        idle(4);

        // Cursor blink over 64 frames
        do_reset();
        cursorRow = 5'd2; cursorCol = 7'd10; cursorEnable = 1; scrollRow = 5'd0;
        for (int f = 1; f <= 64; f++) begin
            vsync_pulse();
            for (int ln = 0; ln < 45; ln++) begin
                for (int x = 80; x < 88; x++) begin
                    hCountIn = 10'(x); deIn = 1;
                    if (ln == 43 && x == 80) mk_f[f-1] = cyc;
                    tick();
                end
                deIn = 0; tick(); tick();
            end
        end
        idle(4);
        for (int f = 1; f <= 64; f++) begin
`ifdef CURSOR_BLINK_EN
            expv = ((f % 32) >= 16);
`else
            expv = 1'b1;
`endif
            check("cursor per frame", 32'(out_log[mk_f[f-1]]), 32'(expv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
